hub75_fb_rowload: RTL and testbench

Responder for the scan controller's frame-buffer row interface. On a row-load request it fetches one full row of pixels from frame memory and writes them into the back bank of a ping-pong line buffer, then signals ready. On a swap request it exchanges front and back banks. The front bank is what the pixel shifter reads.

---
 rtl/hub75_fb_rowload.sv | 96 +++++++++
 tb/tb_hub75_fb_rowload.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_rowload.sv
// Fetches one frame-memory row into the back bank of a ping-pong line buffer; swaps banks on request.
// Latency: fbr_re T+1..T+N_COLS, lb_we T+2..T+N_COLS+1, fb_row_rdy at T+N_COLS+2 after a load at T; no backpressure.
module hub75_fb_rowload #(
  parameter int N_ROWS     = 32,
  parameter int N_COLS     = 64,
  parameter int BITDEPTH   = 16,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LOG_N_ROWS-1:0]          fb_row_addr,
  input  logic                           fb_row_load,
  output logic                           fb_row_rdy,
  input  logic                           fb_row_swap,
  output logic [LOG_N_ROWS+LOG_N_COLS-1:0] fbr_addr,
  output logic                           fbr_re,
  input  logic [BITDEPTH-1:0]            fbr_data,
  output logic [LOG_N_COLS:0]            lb_waddr,
  output logic [BITDEPTH-1:0]            lb_wdata,
  output logic                           lb_we,
  output logic                           front_sel
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [LOG_N_ROWS-1:0]   row;
  logic [LOG_N_COLS-1:0]   col;
  logic                    wbank;
  logic                    start, done;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fb_row_load) begin
          start     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        if (&col) state_nxt = DRAIN;
      end
      DRAIN: begin
        // wait until the last read has been issued and its word is on fbr_data
        if (!fbr_re) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      wbank      <= 1'b0;
      fbr_re     <= 1'b0;
      fbr_addr   <= '0;
      lb_we      <= 1'b0;
      lb_waddr   <= '0;
      front_sel  <= 1'b0;
      fb_row_rdy <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        row   <= fb_row_addr;
        // a swap in the same cycle makes the current front the new back bank
        wbank <= fb_row_swap ? front_sel : ~front_sel;
        col   <= '0;
      end
      fbr_re <= (state == READ);
      if (state == READ) begin
        fbr_addr <= {row, col};
        col      <= col + 1'b1;
      end
      lb_we <= fbr_re;
      if (fbr_re) lb_waddr <= {wbank, fbr_addr[LOG_N_COLS-1:0]};
      if (fb_row_swap) front_sel <= ~front_sel;
      if (done)
        fb_row_rdy <= 1'b1;
      else if (start || fb_row_swap)
        fb_row_rdy <= 1'b0;
    end
  end

  // memory data already carries its own one-cycle latency, aligned with lb_we
  assign lb_wdata = lb_we ? fbr_data : '0;

endmodule

// File: tb/tb_hub75_fb_rowload.sv
// Directed bench for hub75_fb_rowload: row loads, swaps, ignored loads, mid-load reset and a full frame.
module tb_hub75_fb_rowload;
  localparam int N_ROWS = 32;
  localparam int N_COLS = 64;
  localparam int BD     = 16;
  localparam int LR     = 5;
  localparam int LC     = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [LR-1:0]   fb_row_addr = '0;
  logic            fb_row_load = 1'b0;
  logic            fb_row_rdy;
  logic            fb_row_swap = 1'b0;
  logic [LR+LC-1:0] fbr_addr;
  logic            fbr_re;
  logic [BD-1:0]   fbr_data = '0;
  logic [LC:0]     lb_waddr;
  logic [BD-1:0]   lb_wdata;
  logic            lb_we;
  logic            front_sel;

  logic [BD-1:0]   lb_mem [0:2*N_COLS-1];

  int checks = 0;
  int errors = 0;
  bit exp_front = 1'b0;

  always #5 clk = ~clk;

  hub75_fb_rowload #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .BITDEPTH(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fb_row_addr(fb_row_addr),
    .fb_row_load(fb_row_load),
    .fb_row_rdy (fb_row_rdy),
    .fb_row_swap(fb_row_swap),
    .fbr_addr   (fbr_addr),
    .fbr_re     (fbr_re),
    .fbr_data   (fbr_data),
    .lb_waddr   (lb_waddr),
    .lb_wdata   (lb_wdata),
    .lb_we      (lb_we),
    .front_sel  (front_sel)
  );

  // frame memory returns its own address; line buffer captures writes
  always @(posedge clk) begin
    if (fbr_re) fbr_data <= BD'(fbr_addr);
    if (lb_we) lb_mem[lb_waddr] <= lb_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_swap();
    @(negedge clk);
    fb_row_swap = 1'b1;
    @(posedge clk);
    #1;
    fb_row_swap = 1'b0;
    exp_front = ~exp_front;
    chk("swap_front", front_sel, exp_front);
    chk("swap_rdy", fb_row_rdy, 0);
  endtask

  task automatic do_load(input logic [LR-1:0] row, input int inj_k, input bit inj_load,
                         input bit inj_swap, input bit same_swap, input int rst_k);
    int re_cnt = 0, we_cnt = 0, addr_bad = 0, wr_bad = 0, rdy_bad = 0, lb_bad = 0;
    int rdy_k = -1;
    bit bank;
    bank = same_swap ? exp_front : ~exp_front;
    @(negedge clk);
    fb_row_addr = row;
    fb_row_load = 1'b1;
    fb_row_swap = same_swap;
    @(posedge clk);
    #1;
    fb_row_load = 1'b0;
    fb_row_swap = 1'b0;
    if (same_swap) exp_front = ~exp_front;
    chk("rdy_clr", fb_row_rdy, 0);
    for (int k = 1; k <= N_COLS + 4; k++) begin
      @(posedge clk);
      #1;
      fb_row_load = 1'b0;
      fb_row_swap = 1'b0;
      if (fbr_re) begin
        re_cnt++;
        if (k < 1 || k > N_COLS || fbr_addr !== {row, LC'(k - 1)}) addr_bad++;
      end
      if (lb_we) begin
        we_cnt++;
        if (k < 2 || k > N_COLS + 1 || lb_waddr !== {bank, LC'(k - 2)} ||
            lb_wdata !== BD'({row, LC'(k - 2)})) wr_bad++;
      end
      if (fb_row_rdy && rdy_k < 0) rdy_k = k;
      if (rdy_k >= 0 && !fb_row_rdy) rdy_bad++;
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {fbr_re, lb_we, fb_row_rdy, front_sel}, 0);
        chk("rst_mid_fbr_addr", fbr_addr, 0);
        chk("rst_mid_lb", {lb_waddr, lb_wdata}, 0);
        exp_front = 1'b0;
        return;
      end
      if (k == inj_k) begin
        @(negedge clk);
        if (inj_load) begin
          fb_row_addr = LR'(row + 5'd4);
          fb_row_load = 1'b1;
        end
        if (inj_swap) begin
          fb_row_swap = 1'b1;
          exp_front = ~exp_front;
        end
      end
    end
    for (int c = 0; c < N_COLS; c++)
      if (lb_mem[{bank, LC'(c)}] !== BD'({row, LC'(c)})) lb_bad++;
    chk("re_count", re_cnt, N_COLS);
    chk("re_addr", addr_bad, 0);
    chk("we_count", we_cnt, N_COLS);
    chk("we_addr_data", wr_bad, 0);
    chk("rdy_cycle", rdy_k, N_COLS + 2);
    chk("rdy_hold", rdy_bad, 0);
    chk("front_after", front_sel, exp_front);
    chk("lb_contents", lb_bad, 0);
  endtask

  initial begin
    int bad, done_cnt, tmo, w;
    #1;
    chk("rst_ctl", {fbr_re, lb_we, fb_row_rdy, front_sel}, 0);
    chk("rst_fbr_addr", fbr_addr, 0);
    chk("rst_lb", {lb_waddr, lb_wdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({fbr_re, lb_we, fb_row_rdy, front_sel} !== 4'b0) bad++;
    end
    chk("idle_100", bad, 0);

    do_load(5'd5, 0, 1'b0, 1'b0, 1'b0, 0);    // bank 1
    do_swap();
    do_load(5'd6, 0, 1'b0, 1'b0, 1'b0, 0);    // bank 0
    do_load(5'd7, 21, 1'b1, 1'b0, 1'b0, 0);   // stray load at col 20 ignored
    do_load(5'd10, 0, 1'b0, 1'b0, 1'b1, 0);   // swap with load: front->0, bank 1
    do_load(5'd11, 21, 1'b0, 1'b1, 1'b0, 0);  // swap mid-read, still bank 1
    do_load(5'd12, 0, 1'b0, 1'b0, 1'b0, 11);  // reset on the 10th write
    @(negedge clk);
    rst_n = 1'b1;
    do_load(5'd3, 0, 1'b0, 1'b0, 1'b0, 0);

    done_cnt = 0;
    tmo = 0;
    for (int r = 0; r < N_ROWS; r++) begin
      @(negedge clk);
      fb_row_addr = LR'(r);
      fb_row_load = 1'b1;
      @(posedge clk);
      #1;
      fb_row_load = 1'b0;
      w = 0;
      while (!fb_row_rdy && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (fb_row_rdy) done_cnt++;
      else tmo++;
      @(negedge clk);
      fb_row_swap = 1'b1;
      @(posedge clk);
      #1;
      fb_row_swap = 1'b0;
    end
    chk("frame_loads", done_cnt, N_ROWS);
    chk("frame_timeouts", tmo, 0);
    chk("frame_front", front_sel, 0);
    chk("frame_rdy_after_swap", fb_row_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
